// File: rtl/muldiv_ctrl.sv
// Sequencer and HI/LO interlock for the shared iterative multiply/divide unit.
// Decodes the ID instruction, launches the unit, counts its steps and stalls dependents.
module muldiv_ctrl #(
    parameter int MUL_CYCLES = 32,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             id_valid,
    input  logic             flush,
    output logic             md_start,
    output logic [1:0]       md_op,
    output logic             md_step,
    output logic             hilo_we,
    output logic             busy,
    output logic [CNT_W-1:0] remain,
    output logic             en_pc,
    output logic             hazard
);

    typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
    localparam bit CFG_OK = (MUL_CYCLES >= 1) && (DIV_CYCLES >= 1) &&
                            (MUL_CYCLES < (2 ** CNT_W)) && (DIV_CYCLES < (2 ** CNT_W));

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             is_special;
    logic             is_md;
    logic             is_hilo;
    logic             issue;
    logic             unused_instr_bits;

    // funct 24..27 (mul/div) and 16..19 (HI/LO moves) differ only in the two low bits
    assign is_special        = (instr[31:26] == 6'd0);
    assign is_md             = is_special && (instr[5:2] == 4'b0110);
    assign is_hilo           = is_special && (instr[5:2] == 4'b0100);
    assign unused_instr_bits = ^instr[25:6];

    assign busy    = (state != IDLE);
    assign hazard  = id_valid & ~flush & (is_md | is_hilo) & busy;
    assign en_pc   = ~hazard;
    assign issue   = id_valid & ~flush & is_md & (state == IDLE) & ~hazard;
    assign md_step = (state == RUN) & ~md_start;
    assign hilo_we = (state == WB);
    assign remain  = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            md_op    <= '0;
            md_start <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        state    <= RUN;
                        md_op    <= instr[1:0];
                        count    <= instr[1] ? DIV_LOAD : MUL_LOAD;
                        md_start <= 1'b1;
                    end
                end
                RUN: begin
                    if (md_start) begin
                        md_start <= 1'b0;
                    end else if (count == CNT_W'(1)) begin
                        state <= WB;
                        count <= '0;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                WB: begin
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    count    <= '0;
                    md_start <= 1'b0;
                end
            endcase
        end
    end

    a_cfg: assert property (@(posedge clk) CFG_OK)
        else $error("muldiv_ctrl: cycle parameters out of range for CNT_W");

    a_no_wrap: assert property (@(posedge clk) disable iff (rst) md_step |-> (count != '0))
        else $error("muldiv_ctrl: step with zero count");

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomised and directed bench for muldiv_ctrl: a timeline model predicts each operation's
// start/write-back window and a monitor compares the DUT's pulses against the queued predictions.
module tb_muldiv_ctrl;

    localparam int MULN = 32;
    localparam int DIVN = 32;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        id_valid;
    logic        flush;
    logic        md_start;
    logic [1:0]  md_op;
    logic        md_step;
    logic        hilo_we;
    logic        busy;
    logic [5:0]  remain;
    logic        en_pc;
    logic        hazard;

    logic [31:0] instr4;
    logic        id_valid4;
    logic        md_start4;
    logic [1:0]  md_op4;
    logic        md_step4;
    logic        hilo_we4;
    logic        busy4;
    logic [2:0]  remain4;
    logic        en_pc4;
    logic        hazard4;

    muldiv_ctrl #(.MUL_CYCLES(MULN), .DIV_CYCLES(DIVN), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .instr(instr), .id_valid(id_valid), .flush(flush),
        .md_start(md_start), .md_op(md_op), .md_step(md_step), .hilo_we(hilo_we),
        .busy(busy), .remain(remain), .en_pc(en_pc), .hazard(hazard)
    );

    muldiv_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(3), .CNT_W(3)) dut4 (
        .clk(clk), .rst(rst), .instr(instr4), .id_valid(id_valid4), .flush(1'b0),
        .md_start(md_start4), .md_op(md_op4), .md_step(md_step4), .hilo_we(hilo_we4),
        .busy(busy4), .remain(remain4), .en_pc(en_pc4), .hazard(hazard4)
    );

    typedef struct {
        int op;
        int start;
        int wb;
        int n;
    } exp_t;

    exp_t sbq[$];
    exp_t act;
    bit   have_act;
    int   cyc;
    int   busy_until;
    int   n_cmp;
    int   n_err;

    localparam logic [5:0] F_MULT = 6'd24, F_MULTU = 6'd25, F_DIV = 6'd26, F_DIVU = 6'd27;
    localparam logic [5:0] F_MFHI = 6'd16, F_MTHI = 6'd17, F_MFLO = 6'd18, F_MTLO = 6'd19;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic bit is_md(input logic [31:0] ins);
        return (ins[31:26] == 6'd0) && (ins[5:0] inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
    endfunction

    function automatic bit is_hilo(input logic [31:0] ins);
        return (ins[31:26] == 6'd0) && (ins[5:0] inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO});
    endfunction

    function automatic logic [31:0] rtype(input logic [5:0] funct);
        logic [31:0] r;
        r = $urandom();
        return {6'd0, r[19:0], funct};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 9))
            0, 1, 2: return rtype(6'(24 + $urandom_range(0, 3)));
            3, 4:    return rtype(6'(16 + $urandom_range(0, 3)));
            5:       return rtype(6'd32);
            6:       return {6'd35, r[25:0]};
            7:       return {6'd4, r[25:0]};
            8:       return {6'd35, r[25:6], F_DIV};
            default: return 32'd0;
        endcase
    endfunction

    // One ID cycle: drive, check the stall against the model, record any issue.
    task automatic step(input logic [31:0] ins, input logic v, input logic fl, output logic stalled);
        bit   mbusy;
        bit   exp_hz;
        exp_t e;
        @(negedge clk);
        instr    = ins;
        id_valid = v;
        flush    = fl;
        #1;
        mbusy  = (cyc <= busy_until);
        exp_hz = v && !fl && (is_md(ins) || is_hilo(ins)) && mbusy;
        chk("hazard", int'(hazard), int'(exp_hz));
        chk("en_pc", int'(en_pc), int'(!exp_hz));
        if (v && !fl && is_md(ins) && !mbusy) begin
            e.op    = int'(ins[1:0]);
            e.n     = ins[1] ? DIVN : MULN;
            e.start = cyc + 1;
            e.wb    = cyc + e.n + 2;
            busy_until = e.wb;
            sbq.push_back(e);
        end
        stalled = exp_hz;
    endtask

    task automatic idle(input int n);
        logic s;
        for (int i = 0; i < n; i++) step(32'd0, 1'b0, 1'b0, s);
    endtask

    task automatic issue_hold(input logic [31:0] ins, output int dut_stalls);
        logic s;
        int   k;
        dut_stalls = 0;
        k = 0;
        do begin
            step(ins, 1'b1, 1'b0, s);
            if (!en_pc) dut_stalls++;
            k++;
        end while (s && k < 200);
        if (k >= 200) chk("hold_timeout", k, 0);
    endtask

    // Monitor: pops an expectation on each md_start and tracks it to its write-back.
    initial begin
        int exp_rem;
        forever begin
            @(negedge clk);
            #2;
            if (md_start) begin
                n_cmp++;
                if (have_act || sbq.size() == 0) begin
                    n_err++;
                    $display("FAIL md_start_unexpected: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    act = sbq.pop_front();
                    have_act = 1'b1;
                    chk("md_start_cycle", cyc, act.start);
                end
            end
            if (have_act) begin
                exp_rem = (cyc == act.start) ? act.n :
                          (cyc < act.wb) ? act.n + 1 - (cyc - act.start) : 0;
                chk("busy", int'(busy), 1);
                chk("md_op", int'(md_op), act.op);
                chk("md_step", int'(md_step), int'(cyc > act.start && cyc < act.wb));
                chk("hilo_we", int'(hilo_we), int'(cyc == act.wb));
                chk("remain", int'(remain), exp_rem);
                if (cyc >= act.wb) have_act = 1'b0;
            end else begin
                chk("busy_idle", int'(busy), 0);
                chk("hilo_we_idle", int'(hilo_we), 0);
                chk("md_step_idle", int'(md_step), 0);
                chk("remain_idle", int'(remain), 0);
                if (sbq.size() > 0 && cyc >= sbq[0].start) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL md_start_missing: got 0 expected 1 (cycle %0d)", cyc);
                    void'(sbq.pop_front());
                end
            end
        end
    end

    initial begin
        logic        s;
        logic [31:0] cur;
        int          st;
        int          tgt;
        int          busy_cnt;
        int          wb_idx;
        cyc = 0; n_cmp = 0; n_err = 0; busy_until = -1; have_act = 1'b0;
        rst = 1'b1; instr = '0; id_valid = 1'b0; flush = 1'b0;
        instr4 = '0; id_valid4 = 1'b0;

        #8;
        chk("rst_busy", int'(busy), 0);
        chk("rst_md_start", int'(md_start), 0);
        chk("rst_md_op", int'(md_op), 0);
        chk("rst_remain", int'(remain), 0);
        chk("rst_en_pc", int'(en_pc), 1);
        @(negedge clk);
        rst = 1'b0;

        // DIVU from idle, then quiet
        step(rtype(F_DIVU), 1'b1, 1'b0, s);
        idle(36);

        // MULT followed by MFLO: held for the whole occupancy
        step(rtype(F_MULT), 1'b1, 1'b0, s);
        issue_hold(rtype(F_MFLO), st);
        chk("mflo_stall_cycles", st, MULN + 2);
        idle(3);

        // back-to-back DIVs
        step(rtype(F_DIV), 1'b1, 1'b0, s);
        issue_hold(rtype(F_DIV), st);
        chk("div2_stall_cycles", st, DIVN + 2);
        idle(36);

        // flushed DIV never issues; flush mid-run does not abort
        step(rtype(F_DIV), 1'b1, 1'b1, s);
        idle(3);
        step(rtype(F_DIV), 1'b1, 1'b0, s);
        idle(5);
        step(rtype(F_MFLO), 1'b1, 1'b1, s);
        step(rtype(F_DIV), 1'b1, 1'b1, s);
        // unrelated instructions while busy
        step(rtype(6'd32), 1'b1, 1'b0, s);
        step({6'd35, 26'h1234}, 1'b1, 1'b0, s);
        step({6'd4, 26'h0042}, 1'b1, 1'b0, s);
        step(32'd0, 1'b1, 1'b0, s);
        idle(36);

        // asynchronous reset mid-run at remain==10
        step(rtype(F_DIV), 1'b1, 1'b0, s);
        tgt = cyc + 1 + (DIVN + 1 - 10);
        while (cyc < tgt) step(32'd0, 1'b0, 1'b0, s);
        #2;
        chk("pre_rst_remain", int'(remain), 10);
        #1;
        rst = 1'b1;
        sbq.delete();
        have_act   = 1'b0;
        busy_until = -1;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_md_step", int'(md_step), 0);
        chk("arst_hilo_we", int'(hilo_we), 0);
        chk("arst_remain", int'(remain), 0);
        chk("arst_md_op", int'(md_op), 0);
        chk("arst_hazard", int'(hazard), 0);
        @(negedge clk);
        #4;
        rst = 1'b0;
        idle(DIVN);
        step(rtype(F_DIV), 1'b1, 1'b0, s);
        idle(36);

        // random traffic
        s = 1'b0;
        cur = '0;
        for (int i = 0; i < 600; i++) begin
            if (!s) cur = rand_instr();
            step(cur, ($urandom() % 8) != 0, ($urandom() % 10) == 0, s);
        end
        idle(40);

        // short-latency build: MULTU occupies 4 + 2 cycles
        @(negedge clk);
        id_valid = 1'b0;
        instr4 = rtype(F_MULTU);
        id_valid4 = 1'b1;
        @(negedge clk);
        instr4 = rtype(6'd32);
        busy_cnt = 0;
        wb_idx = -1;
        for (int k = 1; k <= 10; k++) begin
            #1;
            if (busy4) busy_cnt++;
            if (hilo_we4) wb_idx = k;
            chk("short_add_hazard", int'(hazard4), 0);
            @(negedge clk);
        end
        id_valid4 = 1'b0;
        chk("short_occupancy", busy_cnt, 6);
        chk("short_wb_cycle", wb_idx, 6);

        idle(4);
        chk("sb_drained", sbq.size(), 0);
        chk("no_open_op", int'(have_act), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
